// File: rtl/irq_pkg.sv
// Shared constants and source names for the GBA interrupt controller.
package irq_pkg;

    localparam int unsigned GBA_NUM_IRQ   = 14;
    localparam logic [4:0]  CPSR_IRQ_MODE = 5'b10010;

    // GBA peripheral interrupt sources, in IE/IF bit order.
    typedef enum logic [3:0] {
        IRQ_VBLANK  = 4'd0,
        IRQ_HBLANK  = 4'd1,
        IRQ_VCOUNT  = 4'd2,
        IRQ_TIMER0  = 4'd3,
        IRQ_TIMER1  = 4'd4,
        IRQ_TIMER2  = 4'd5,
        IRQ_TIMER3  = 4'd6,
        IRQ_SERIAL  = 4'd7,
        IRQ_DMA0    = 4'd8,
        IRQ_DMA1    = 4'd9,
        IRQ_DMA2    = 4'd10,
        IRQ_DMA3    = 4'd11,
        IRQ_KEYPAD  = 4'd12,
        IRQ_GAMEPAK = 4'd13
    } irq_src_e;

    // Keypad is level-sensitive (held key combination); everything else is edge.
    localparam logic [GBA_NUM_IRQ-1:0] GBA_EDGE_MASK = 14'h2FFF;

endpackage

// File: rtl/irq_flag_cell.sv
// One interrupt flag: edge or level capture, set wins over acknowledge.
module irq_flag_cell #(
    parameter bit EDGE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic src,
    input  logic ack,
    output logic flag
);

    logic set_c;

    generate
        if (EDGE) begin : g_edge
            logic src_q;

            // Source history for rising-edge detection; clears to 0 so a
            // source already high after reset counts as an edge.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    src_q <= 1'b0;
                end else begin
                    src_q <= src;
                end
            end

            assign set_c = src & ~src_q;
        end else begin : g_level
            assign set_c = src;
        end
    endgenerate

    // Flag register: a new set beats a simultaneous acknowledge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flag <= 1'b0;
        end else begin
            flag <= set_c | (flag & ~ack);
        end
    end

endmodule

// File: rtl/irq_ctrl_param.sv
// Parametrised interrupt controller: flags, priority index, wake and delayed nIRQ.
module irq_ctrl_param
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC   = GBA_NUM_IRQ,
    parameter logic [15:0] EDGE_MASK = 16'h3FFF,
    parameter int unsigned IRQ_DELAY = 2,
    parameter logic [4:0]  IRQ_MODE  = CPSR_IRQ_MODE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ime,
    input  logic [NUM_SRC-1:0] reg_ie,
    input  logic               ack_we,
    input  logic [NUM_SRC-1:0] ack_mask,
    input  logic [NUM_SRC-1:0] src,
    input  logic [4:0]         cpu_mode,
    output logic [NUM_SRC-1:0] reg_if,
    output logic               irq_n,
    output logic               pend_valid,
    output logic [3:0]         pend_id,
    output logic               wake
);

    localparam int unsigned ID_W = 4;

    logic [NUM_SRC-1:0] flag;
    logic [NUM_SRC-1:0] act;
    logic               act_any;
    logic               req;
    logic               stage_out;
    logic [ID_W-1:0]    enc_id;

    // One capture cell per source.
    generate
        for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_cell
            irq_flag_cell #(
                .EDGE (EDGE_MASK[i])
            ) u_cell (
                .clock (clock),
                .reset (reset),
                .src   (src[i]),
                .ack   (ack_we & ack_mask[i]),
                .flag  (flag[i])
            );
        end
    endgenerate

    assign reg_if  = flag;
    assign act     = flag & reg_ie;
    assign act_any = |act;
    assign req     = act_any & ime & (cpu_mode != IRQ_MODE);

    // Fixed priority: lowest active index wins.
    always_comb begin
        enc_id = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (act[i]) begin
                enc_id = ID_W'(i);
            end
        end
    end

    // Programmable delay between request and the final nIRQ register.
    generate
        if (IRQ_DELAY == 0) begin : g_no_delay
            assign stage_out = req;
        end else begin : g_delay
            logic [IRQ_DELAY-1:0] pipe;

            // Shift request through IRQ_DELAY stages; no cancellation.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    pipe <= '0;
                end else begin
                    pipe[0] <= req;
                    for (int i = 1; i < int'(IRQ_DELAY); i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign stage_out = pipe[IRQ_DELAY-1];
        end
    endgenerate

    // Final nIRQ register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_n <= 1'b1;
        end else begin
            irq_n <= ~stage_out;
        end
    end

    // Pending index and halt wake; pend_id holds while nothing is pending.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_id    <= '0;
            wake       <= 1'b0;
        end else begin
            pend_valid <= act_any;
            wake       <= act_any;
            if (act_any) begin
                pend_id <= enc_id;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl_param.sv
// Directed bench for irq_ctrl_param (keypad source configured level-sensitive).
module tb_irq_ctrl_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        ime;
    logic [13:0] reg_ie;
    logic        ack_we;
    logic [13:0] ack_mask;
    logic [13:0] src;
    logic [4:0]  cpu_mode;
    logic [13:0] reg_if;
    logic        irq_n;
    logic        pend_valid;
    logic [3:0]  pend_id;
    logic        wake;

    int checks   = 0;
    int failures = 0;

    irq_ctrl_param #(
        .NUM_SRC   (14),
        .EDGE_MASK (16'h2FFF),
        .IRQ_DELAY (2),
        .IRQ_MODE  (5'b10010)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ime        (ime),
        .reg_ie     (reg_ie),
        .ack_we     (ack_we),
        .ack_mask   (ack_mask),
        .src        (src),
        .cpu_mode   (cpu_mode),
        .reg_if     (reg_if),
        .irq_n      (irq_n),
        .pend_valid (pend_valid),
        .pend_id    (pend_id),
        .wake       (wake)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic ack(input logic [13:0] m);
        ack_we = 1'b1; ack_mask = m;
        tick(1);
        ack_we = 1'b0; ack_mask = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1; ime = 1'b0; reg_ie = '0; ack_we = 1'b0; ack_mask = '0;
        src = '0; cpu_mode = 5'h1F;
        #3;
        checks++; if (reg_if !== 14'h0) begin failures++; $display("FAIL rst_reg_if got=%h exp=0000", reg_if); end
        checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL rst_irq_n got=%b exp=1", irq_n); end
        checks++; if (pend_valid !== 1'b0) begin failures++; $display("FAIL rst_pend_valid got=%b exp=0", pend_valid); end
        checks++; if (pend_id !== 4'd0) begin failures++; $display("FAIL rst_pend_id got=%0d exp=0", pend_id); end
        checks++; if (wake !== 1'b0) begin failures++; $display("FAIL rst_wake got=%b exp=0", wake); end
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_edge_pulse;
        ime = 1'b1; reg_ie = 14'h0001; cpu_mode = 5'h1F;
        src = 14'h0001;
        tick(1);
        src = '0;
        checks++; if (reg_if !== 14'h0001) begin failures++; $display("FAIL pulse_reg_if got=%h exp=0001", reg_if); end
        checks++; if (pend_valid !== 1'b0) begin failures++; $display("FAIL pulse_pv_early got=%b exp=0", pend_valid); end
        tick(1);
        checks++; if (pend_valid !== 1'b1 || pend_id !== 4'd0) begin failures++; $display("FAIL pulse_pend got=%b/%0d exp=1/0", pend_valid, pend_id); end
        checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL pulse_irq_early got=%b exp=1", irq_n); end
        tick(1);
        checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL pulse_irq_mid got=%b exp=1", irq_n); end
        tick(1);
        checks++; if (irq_n !== 1'b0) begin failures++; $display("FAIL pulse_irq_fall got=%b exp=0", irq_n); end
        ack(14'h0001);
        checks++; if (reg_if !== 14'h0) begin failures++; $display("FAIL pulse_ack got=%h exp=0000", reg_if); end
        tick(2);
        checks++; if (irq_n !== 1'b0) begin failures++; $display("FAIL pulse_irq_hold got=%b exp=0", irq_n); end
        tick(1);
        checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL pulse_irq_rise got=%b exp=1", irq_n); end
    endtask

    task automatic test_edge_hold;
        int bad;
        reg_ie = '0;
        src = 14'h0008;
        tick(1);
        checks++; if (reg_if !== 14'h0008) begin failures++; $display("FAIL hold_set got=%h exp=0008", reg_if); end
        tick(3);
        ack(14'h0008);
        checks++; if (reg_if !== 14'h0) begin failures++; $display("FAIL hold_ack got=%h exp=0000", reg_if); end
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (reg_if !== 14'h0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL hold_reset_while_high cycles=%0d exp=0", bad); end
        src = '0;
        tick(1);
    endtask

    task automatic test_level;
        reg_ie = '0;
        src = 14'h1000;
        tick(1);
        checks++; if (reg_if !== 14'h1000) begin failures++; $display("FAIL lvl_set got=%h exp=1000", reg_if); end
        ack(14'h1000);
        checks++; if (reg_if !== 14'h1000) begin failures++; $display("FAIL lvl_set_wins got=%h exp=1000", reg_if); end
        src = '0;
        tick(1);
        checks++; if (reg_if !== 14'h1000) begin failures++; $display("FAIL lvl_sticky got=%h exp=1000", reg_if); end
        ack(14'h1000);
        checks++; if (reg_if !== 14'h0) begin failures++; $display("FAIL lvl_clear got=%h exp=0000", reg_if); end
        ack_mask = 14'h3FFF;
        src = 14'h1000;
        tick(1);
        src = '0; ack_mask = '0;
        tick(1);
        checks++; if (reg_if !== 14'h1000) begin failures++; $display("FAIL lvl_mask_no_we got=%h exp=1000", reg_if); end
        ack(14'h1000);
    endtask

    task automatic test_priority;
        ime = 1'b0; reg_ie = 14'h0220;
        src = 14'h0220;
        tick(1);
        src = '0;
        checks++; if (reg_if !== 14'h0220) begin failures++; $display("FAIL prio_if got=%h exp=0220", reg_if); end
        tick(1);
        checks++; if (pend_valid !== 1'b1 || pend_id !== 4'd5) begin failures++; $display("FAIL prio_5 got=%b/%0d exp=1/5", pend_valid, pend_id); end
        ack(14'h0020);
        checks++; if (reg_if !== 14'h0200 || pend_id !== 4'd5) begin failures++; $display("FAIL prio_ack5 got=%h/%0d exp=0200/5", reg_if, pend_id); end
        tick(1);
        checks++; if (pend_valid !== 1'b1 || pend_id !== 4'd9) begin failures++; $display("FAIL prio_9 got=%b/%0d exp=1/9", pend_valid, pend_id); end
        ack(14'h0200);
        tick(1);
        checks++; if (pend_valid !== 1'b0 || pend_id !== 4'd9) begin failures++; $display("FAIL prio_hold got=%b/%0d exp=0/9", pend_valid, pend_id); end
        checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL prio_ime_off got=%b exp=1", irq_n); end
    endtask

    task automatic test_masking;
        ime = 1'b0; reg_ie = 14'h0002; cpu_mode = 5'h1F;
        src = 14'h0002;
        tick(1);
        src = '0;
        tick(1);
        checks++; if (wake !== 1'b1) begin failures++; $display("FAIL mask_wake got=%b exp=1", wake); end
        tick(3);
        checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL mask_ime0 got=%b exp=1", irq_n); end
        ime = 1'b1; cpu_mode = 5'b10010;
        tick(4);
        checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL mask_irq_mode got=%b exp=1", irq_n); end
        checks++; if (wake !== 1'b1) begin failures++; $display("FAIL mask_wake_mode got=%b exp=1", wake); end
        cpu_mode = 5'h1F;
        tick(2);
        checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL mask_unmask_early got=%b exp=1", irq_n); end
        tick(1);
        checks++; if (irq_n !== 1'b0) begin failures++; $display("FAIL mask_unmask_fall got=%b exp=0", irq_n); end
        ack(14'h0002);
        tick(4);
    endtask

    task automatic test_reset_mid;
        ime = 1'b1; reg_ie = 14'h3FFF; cpu_mode = 5'h1F;
        src = 14'h3FFF;
        tick(1);
        src = '0;
        tick(4);
        checks++; if (reg_if !== 14'h3FFF || irq_n !== 1'b0) begin failures++; $display("FAIL mid_pre got=%h/%b exp=3FFF/0", reg_if, irq_n); end
        #2;
        src = 14'h0001; reset = 1'b1;
        #1;
        checks++; if (reg_if !== 14'h0) begin failures++; $display("FAIL mid_reg_if got=%h exp=0000", reg_if); end
        checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL mid_irq_n got=%b exp=1", irq_n); end
        checks++; if (pend_valid !== 1'b0 || pend_id !== 4'd0) begin failures++; $display("FAIL mid_pend got=%b/%0d exp=0/0", pend_valid, pend_id); end
        checks++; if (wake !== 1'b0) begin failures++; $display("FAIL mid_wake got=%b exp=0", wake); end
        tick(2);
        #2;
        reset = 1'b0; reg_ie = '0;
        tick(1);
        checks++; if (reg_if !== 14'h0001) begin failures++; $display("FAIL mid_release_edge got=%h exp=0001", reg_if); end
        ack(14'h0001);
        tick(1);
        checks++; if (reg_if !== 14'h0) begin failures++; $display("FAIL mid_single_edge got=%h exp=0000", reg_if); end
        src = '0;
    endtask

    initial begin
        test_reset();
        test_edge_pulse();
        test_edge_hold();
        test_level();
        test_priority();
        test_masking();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
